// File: rtl/prism_cfg_pkg.sv
// Shared definitions for the PRISM configuration readback path: register offsets,
// FSM state and operation enums, and the CRC-CCITT constants and bit-serial update.
package prism_cfg_pkg;

  localparam logic [5:0] RegPtr = 6'h10;
  localparam logic [5:0] RegLo  = 6'h14;
  localparam logic [5:0] RegHi  = 6'h18;
  localparam logic [5:0] RegCrc = 6'h1C;

  localparam logic [15:0] CrcPoly = 16'h1021;
  localparam logic [15:0] CrcInit = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSelect,
    StPresent,
    StDone
  } reader_state_e;

  typedef enum logic [1:0] {
    OpPtr,
    OpLo,
    OpHi,
    OpCrc
  } reader_op_e;

  // Feeds the low nbits of data into the CRC, most significant bit first.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [63:0] data,
                                               input int unsigned nbits);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      if (i < int'(nbits)) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ CrcPoly;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/prism_config_reader_if.sv
// Peripheral bus seen by the PRISM config reader: core-driven request side plus
// the reader's hit/data/ready response.
interface prism_config_reader_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic        hit;
  logic [31:0] rd_data;
  logic        rd_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  hit, rd_data, rd_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output hit, rd_data, rd_ready
  );
endinterface

// File: rtl/prism_cfg_word_mux.sv
// Registered DEPTH:1 selector picking one WIDTH-bit entry out of the latch chain.
module prism_cfg_word_mux #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PTR_W-1:0]       sel,
  input  logic [WIDTH*DEPTH-1:0] entries,
  output logic [WIDTH-1:0]       q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= entries[32'(sel)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/prism_config_reader.sv
// PRISM config chain readback: PTR / DATA_LO / DATA_HI registers with an atomic
// snapshot. Optional CRC-CCITT over snapshots at 0x1C when PRISM_CFG_CRC_EN is defined.
module prism_config_reader
  import prism_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prism_config_reader_if.slave   bus,
  input  logic [WIDTH*DEPTH-1:0] config_bus,
  input  logic                   loader_busy,
  output logic [PTR_W-1:0]       rd_ptr
);

  reader_state_e    state_q, state_d;
  reader_op_e       op_q, op_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] holding_q, holding_d;
  logic [WIDTH-1:0] mux_q;
  logic             mux_en;
  logic             read_req, write_req;
  logic             hit_ptr, hit_lo, hit_hi, hit_crc;
  logic [31:0]      word, crc_word;

  assign read_req  = bus.data_read_n != 2'b11;
  assign write_req = bus.data_write_n != 2'b11;
  assign hit_ptr   = bus.address == RegPtr;
  assign hit_lo    = bus.address == RegLo;
  assign hit_hi    = bus.address == RegHi;
`ifdef PRISM_CFG_CRC_EN
  assign hit_crc   = bus.address == RegCrc;
`else
  assign hit_crc   = 1'b0;
`endif
  assign bus.hit   = hit_ptr | hit_lo | hit_hi | hit_crc;
  assign rd_ptr    = ptr_q;

  prism_cfg_word_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_word_mux (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (mux_en),
    .sel     (ptr_q),
    .entries (config_bus),
    .q       (mux_q)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    holding_d = holding_q;
    mux_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write_req && hit_ptr) ptr_d = bus.data_in[PTR_W-1:0];
        if (read_req) begin
          if (hit_lo) begin
            op_d    = OpLo;
            state_d = loader_busy ? StWait : StSelect;
          end else if (hit_ptr) begin
            op_d    = OpPtr;
            state_d = StPresent;
          end else if (hit_hi) begin
            op_d    = OpHi;
            state_d = StPresent;
          end else if (hit_crc) begin
            op_d    = OpCrc;
            state_d = StPresent;
          end
        end
      end
      StWait: begin
        if (!loader_busy) state_d = StSelect;
      end
      StSelect: begin
        // A capture taken while the loader is active may be torn; retry it.
        mux_en  = 1'b1;
        state_d = loader_busy ? StWait : StPresent;
      end
      StPresent: begin
        state_d = StDone;
        if (op_q == OpLo) holding_d = mux_q;
        if (op_q == OpHi) ptr_d = ptr_q + PTR_W'(1);
      end
      StDone: begin
        if (!read_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpPtr;
      ptr_q     <= '0;
      holding_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      holding_q <= holding_d;
    end
  end

`ifdef PRISM_CFG_CRC_EN
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == StIdle && write_req && hit_crc) begin
      crc_d = CrcInit;
    end else if (state_q == StPresent && op_q == OpLo) begin
      crc_d = crc16_update(crc_q, 64'(mux_q), WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_word = {16'h0000, crc_q};
`else
  assign crc_word = 32'h0;
`endif

  // The LO word is presented straight from the mux register, i.e. the value holding takes.
  always_comb begin
    word = 32'h0;
    unique case (op_q)
      OpPtr: word = {loader_busy, {(31 - PTR_W){1'b0}}, ptr_q};
      OpLo:  word = mux_q[31:0];
      OpHi:  word = 32'(holding_q[WIDTH-1:32]);
      OpCrc: word = crc_word;
      default: word = 32'h0;
    endcase
  end

  assign bus.rd_ready = state_q == StPresent;
  assign bus.rd_data  = bus.rd_ready ? word : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.data_in[31:PTR_W], holding_q[31:0]};

endmodule

// File: tb/tb_prism_config_reader.sv
// Randomized self-checking bench for prism_config_reader against a behavioural model
// (pointer, snapshot and CRC tracked as plain variables). Covers PRISM_CFG_CRC_EN both ways.
module tb_prism_config_reader;

  localparam int W  = 48;
  localparam int D  = 8;
  localparam int PW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W*D-1:0]   config_bus;
  logic             loader_busy;
  logic [PW-1:0]    rd_ptr;
  logic [W-1:0]     cfg [D];

  int vectors = 0;
  int miscompares = 0;

  int          m_ptr;
  logic [47:0] m_hold;
  logic [15:0] m_crc;

  always #5 clk = ~clk;

  always_comb begin
    config_bus = '0;
    for (int i = 0; i < D; i++) config_bus[i*W +: W] = cfg[i];
  end

  prism_config_reader_if bus_if ();

  prism_config_reader #(
    .WIDTH (W),
    .DEPTH (D),
    .PTR_W (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .config_bus  (config_bus),
    .loader_busy (loader_busy),
    .rd_ptr      (rd_ptr)
  );

  // CRC-CCITT as polynomial long division of the 48-bit message, MSB first.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [47:0] msg);
    logic [15:0] r;
    r = c;
    for (int i = 47; i >= 0; i--) begin
      if (r[15] != msg[i]) r = (r << 1) ^ 16'h1021;
      else r = r << 1;
    end
    return r;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [31:0] v);
    bus_if.address      = a;
    bus_if.data_in      = v;
    bus_if.data_write_n = 2'b00;
    @(negedge clk);
    bus_if.data_write_n = 2'b11;
  endtask

  // Returns read data, latency in cycles (-1 on timeout) and rd_ready one cycle later.
  task automatic do_read(input logic [5:0] a, output logic [31:0] d, output int lat,
                         output logic after);
    d   = 32'h0;
    lat = -1;
    bus_if.address     = a;
    bus_if.data_read_n = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus_if.rd_ready === 1'b1) begin
        d   = bus_if.rd_data;
        lat = i;
        break;
      end
    end
    bus_if.data_read_n = 2'b11;
    @(negedge clk);
    after = bus_if.rd_ready;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          lat;
    logic        after;
    vectors++;
    if (bus_if.rd_ready !== 1'b0 || bus_if.rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd_ready=%b rd_data=%h, required 0/00000000",
               bus_if.rd_ready, bus_if.rd_data);
    end
    vectors++;
    if (rd_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ptr: got %0d, required 0", rd_ptr);
    end
    bus_if.address = 6'h10;
    #1;
    vectors++;
    if (bus_if.hit !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_ptr: got %b, required 1", bus_if.hit);
    end
    bus_if.address = 6'h00;
    #1;
    vectors++;
    if (bus_if.hit !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_unmapped: got %b, required 0", bus_if.hit);
    end
    @(negedge clk);
    // HI without a prior LO: stale (reset) holding, pointer still advances.
    do_read(6'h18, d, lat, after);
    m_ptr = (m_ptr + 1) % D;
    vectors++;
    if (d !== 32'h0 || lat !== 1) begin
      miscompares++;
      $display("FAIL stale_hi: data=%h lat=%0d, required 00000000 lat=1", d, lat);
    end
    vectors++;
    if (rd_ptr !== 3'(m_ptr)) begin
      miscompares++;
      $display("FAIL stale_hi_ptr: got %0d, required %0d", rd_ptr, m_ptr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int          lat;
    logic        after;
    cfg[3] = 48'hABCD_1234_5678;
    do_write(6'h10, 32'd3);
    m_ptr = 3;
    do_read(6'h14, d, lat, after);
    m_hold = cfg[3];
    m_crc  = ref_crc(m_crc, m_hold);
    vectors++;
    if (d !== 32'h1234_5678 || lat !== 2) begin
      miscompares++;
      $display("FAIL basic_lo: data=%h lat=%0d, required 12345678 lat=2", d, lat);
    end
    vectors++;
    if (after !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_strobe: rd_ready after strobe=%b, required 0", after);
    end
    do_read(6'h18, d, lat, after);
    m_ptr = (m_ptr + 1) % D;
    vectors++;
    if (d !== 32'h0000_ABCD || lat !== 1) begin
      miscompares++;
      $display("FAIL basic_hi: data=%h lat=%0d, required 0000abcd lat=1", d, lat);
    end
    do_read(6'h10, d, lat, after);
    vectors++;
    if (d !== 32'h0000_0004 || lat !== 1) begin
      miscompares++;
      $display("FAIL basic_ptr: data=%h lat=%0d, required 00000004 lat=1", d, lat);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int          lat;
    logic        after;
    cfg[7] = 48'h0102_0304_0506;
    do_write(6'h10, 32'd7);
    m_ptr = 7;
    do_read(6'h14, d, lat, after);
    m_hold = cfg[7];
    m_crc  = ref_crc(m_crc, m_hold);
    do_read(6'h18, d, lat, after);
    m_ptr = (m_ptr + 1) % D;
    vectors++;
    if (d !== 32'h0000_0102) begin
      miscompares++;
      $display("FAIL wrap_hi: data=%h, required 00000102", d);
    end
    do_read(6'h10, d, lat, after);
    vectors++;
    if (d !== 32'h0 || rd_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL wrap_ptr: data=%h rd_ptr=%0d, required 00000000 and 0", d, rd_ptr);
    end
  endtask

  task automatic test_busy();
    logic [31:0] d;
    logic        early;
    int          lat;
    logic [47:0] r;
    r = {$urandom(), $urandom()};
    cfg[5] = r[47:0];
    do_write(6'h10, 32'd5);
    m_ptr = 5;
    bus_if.address     = 6'h14;
    bus_if.data_read_n = 2'b00;
    loader_busy        = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.rd_ready !== 1'b0) early = 1'b1;
    end
    loader_busy = 1'b0;
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus_if.rd_ready === 1'b1) begin
        lat = i;
        d   = bus_if.rd_data;
        break;
      end
    end
    bus_if.data_read_n = 2'b11;
    repeat (2) @(negedge clk);
    m_hold = cfg[5];
    m_crc  = ref_crc(m_crc, m_hold);
    vectors++;
    if (early !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("FAIL busy_wait: early=%b lat=%0d, required 0 lat=2", early, lat);
    end
    vectors++;
    if (d !== m_hold[31:0]) begin
      miscompares++;
      $display("FAIL busy_data: got %h, required %h", d, m_hold[31:0]);
    end

    // Busy pulse during SELECT, latch change and a write attempt while not idle.
    cfg[6] = 48'h0A0A_1111_2222;
    do_write(6'h10, 32'd6);
    m_ptr = 6;
    bus_if.address     = 6'h14;
    bus_if.data_read_n = 2'b00;
    @(negedge clk);
    loader_busy         = 1'b1;
    cfg[6]              = 48'h0B0B_3333_4444;
    bus_if.address      = 6'h10;
    bus_if.data_in      = 32'd1;
    bus_if.data_write_n = 2'b00;
    @(negedge clk);
    bus_if.data_write_n = 2'b11;
    bus_if.address      = 6'h14;
    loader_busy         = 1'b0;
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus_if.rd_ready === 1'b1) begin
        lat = i;
        d   = bus_if.rd_data;
        break;
      end
    end
    bus_if.data_read_n = 2'b11;
    repeat (2) @(negedge clk);
    m_hold = cfg[6];
    m_crc  = ref_crc(m_crc, m_hold);
    vectors++;
    if (d !== 32'h3333_4444 || lat !== 2) begin
      miscompares++;
      $display("FAIL busy_retry: data=%h lat=%0d, required 33334444 lat=2", d, lat);
    end
    vectors++;
    if (rd_ptr !== 3'(m_ptr)) begin
      miscompares++;
      $display("FAIL write_not_idle: rd_ptr=%0d, required %0d", rd_ptr, m_ptr);
    end
  endtask

  task automatic test_atomic();
    logic [31:0] d;
    int          lat;
    logic        after;
    cfg[2] = 48'h1111_2222_3333;
    do_write(6'h10, 32'd2);
    m_ptr = 2;
    do_read(6'h14, d, lat, after);
    m_hold = cfg[2];
    m_crc  = ref_crc(m_crc, m_hold);
    cfg[2] = 48'hFFFF_0000_0000;
    do_read(6'h18, d, lat, after);
    m_ptr = (m_ptr + 1) % D;
    vectors++;
    if (d !== 32'h0000_1111) begin
      miscompares++;
      $display("FAIL atomic_hi: got %h, required 00001111", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        fired;
    int          lat;
    logic        after;
    logic [47:0] r;
    r = {$urandom(), $urandom()};
    cfg[0] = r[47:0];
    do_write(6'h10, 32'd4);
    bus_if.address     = 6'h14;
    bus_if.data_read_n = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_if.rd_data !== 32'h0 || rd_ptr !== 3'd0) begin
      miscompares++;
      $display("FAIL midreset_state: rd_data=%h rd_ptr=%0d, required 00000000 and 0",
               bus_if.rd_data, rd_ptr);
    end
    bus_if.data_read_n = 2'b11;
    fired = bus_if.rd_ready;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.rd_ready !== 1'b0) fired = 1'b1;
    end
    rst_n = 1'b1;
    m_ptr  = 0;
    m_hold = '0;
    m_crc  = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.rd_ready !== 1'b0) fired = 1'b1;
    end
    vectors++;
    if (fired !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_strobe: rd_ready seen=%b, required 0", fired);
    end
    do_read(6'h14, d, lat, after);
    m_hold = cfg[0];
    m_crc  = ref_crc(m_crc, m_hold);
    vectors++;
    if (d !== m_hold[31:0] || lat !== 2) begin
      miscompares++;
      $display("FAIL midreset_next: data=%h lat=%0d, required %h lat=2", d, lat, m_hold[31:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, v, exp;
    int          lat, op, k;
    logic        after;
    logic [47:0] r;
    logic [5:0]  a;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, D - 1);
      r = {$urandom(), $urandom()};
      cfg[k] = r[47:0];
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          v = $urandom();
          do_write(6'h10, v);
          m_ptr = int'(v % D);
        end
        1: begin
          do_read(6'h14, d, lat, after);
          m_hold = cfg[m_ptr];
          m_crc  = ref_crc(m_crc, m_hold);
          vectors++;
          if (d !== m_hold[31:0] || lat !== 2) begin
            miscompares++;
            $display("FAIL rand_lo: data=%h lat=%0d, required %h lat=2", d, lat, m_hold[31:0]);
          end
        end
        2: begin
          do_read(6'h18, d, lat, after);
          exp   = 32'(m_hold >> 32);
          m_ptr = (m_ptr + 1) % D;
          vectors++;
          if (d !== exp || lat !== 1) begin
            miscompares++;
            $display("FAIL rand_hi: data=%h lat=%0d, required %h lat=1", d, lat, exp);
          end
        end
        3: begin
          do_read(6'h10, d, lat, after);
          vectors++;
          if (d !== 32'(m_ptr) || lat !== 1) begin
            miscompares++;
            $display("FAIL rand_ptr: data=%h lat=%0d, required %h lat=1", d, lat, 32'(m_ptr));
          end
        end
        default: begin
          do begin
            a = 6'($urandom_range(0, 63));
          end while (a == 6'h10 || a == 6'h14 || a == 6'h18 || a == 6'h1C);
          bus_if.address = a;
          #1;
          vectors++;
          if (bus_if.hit !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_unmapped_hit: addr=%h hit=%b, required 0", a, bus_if.hit);
          end
          @(negedge clk);
          if (op == 4) begin
            do_read(a, d, lat, after);
            vectors++;
            if (lat !== -1) begin
              miscompares++;
              $display("FAIL rand_unmapped_rd: addr=%h lat=%0d, required no response", a, lat);
            end
          end else begin
            do_write(a, $urandom());
          end
        end
      endcase
      vectors++;
      if (rd_ptr !== 3'(m_ptr)) begin
        miscompares++;
        $display("FAIL rand_rd_ptr: got %0d, required %0d", rd_ptr, m_ptr);
      end
    end
  endtask

  task automatic test_crc();
    logic [31:0] d;
    int          lat;
    logic        after;
    logic [47:0] r;
`ifdef PRISM_CFG_CRC_EN
    do_write(6'h1C, 32'h0);
    m_crc = 16'hFFFF;
    do_read(6'h1C, d, lat, after);
    vectors++;
    if (d !== 32'h0000_FFFF || lat !== 1) begin
      miscompares++;
      $display("FAIL crc_init: data=%h lat=%0d, required 0000ffff lat=1", d, lat);
    end
    for (int i = 0; i < D; i++) begin
      r = {$urandom(), $urandom()};
      cfg[i] = r[47:0];
      do_write(6'h10, 32'(i));
      m_ptr = i;
      do_read(6'h14, d, lat, after);
      m_hold = cfg[i];
      m_crc  = ref_crc(m_crc, m_hold);
    end
    do_read(6'h1C, d, lat, after);
    vectors++;
    if (d !== {16'h0, m_crc}) begin
      miscompares++;
      $display("FAIL crc_value: got %h, required %h", d, {16'h0, m_crc});
    end
`else
    bus_if.address = 6'h1C;
    #1;
    vectors++;
    if (bus_if.hit !== 1'b0) begin
      miscompares++;
      $display("FAIL crc_absent_hit: got %b, required 0", bus_if.hit);
    end
    @(negedge clk);
    do_read(6'h1C, d, lat, after);
    vectors++;
    if (lat !== -1) begin
      miscompares++;
      $display("FAIL crc_absent_rd: lat=%0d, required no response", lat);
    end
    r = '0;
`endif
  endtask

  initial begin
    rst_n               = 1'b0;
    loader_busy         = 1'b0;
    bus_if.address      = 6'h00;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = 2'b11;
    bus_if.data_read_n  = 2'b11;
    for (int i = 0; i < D; i++) cfg[i] = '0;
    m_ptr  = 0;
    m_hold = '0;
    m_crc  = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_basic();
    test_wrap();
    test_busy();
    test_atomic();
    test_reset_mid();
    test_random();
    test_crc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
